// File: rtl/mmio_timer_responder_pkg.sv
// Shared definitions for the memory-mapped timer peripheral.
//   tmr_reg_e : register select decoded from Address[3:2]
//   CTRL_*    : bit positions inside the CTRL register
package mmio_timer_responder_pkg;

  typedef enum logic [1:0] {
    TMR_CTRL   = 2'd0,
    TMR_LOAD   = 2'd1,
    TMR_COUNT  = 2'd2,
    TMR_STATUS = 2'd3
  } tmr_reg_e;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_AUTO      = 1;
  localparam int CTRL_IE        = 2;
  localparam int CTRL_PRESC_LSB = 8;

  localparam int STATUS_EXP     = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: counts enabled cycles and emits one tick every
// PRESC+1 cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable; the counter is held at 0 while low
//   presc      : terminal value; 0 gives a tick every enabled cycle
//   clear      : forces the counter back to 0 at the next edge
//   tick       : combinational, high when en and the counter equals presc
module timer_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] presc,
  input  logic         clear,
  output logic         tick
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] pc;

  assign tick = en && (pc == presc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clear || !en || tick) begin
      pc <= '0;
    end else begin
      pc <= pc + ONE;
    end
  end

endmodule

// File: rtl/mmio_timer_responder.sv
// Memory-mapped timer that sits beside the data memory on the CPU's load/store
// port. It offers a prescaled 32-bit down-counter with one-shot or auto-reload
// behaviour, a sticky expiry flag and a level interrupt.
//
// Bus protocol: an access is a single cycle with no wait states. A load is
// MemRead high while Hit is high; Read_data is valid combinationally in that
// same cycle. A store is MemWrite high while Hit is high; it commits at the
// rising clk edge that ends the cycle. Accesses outside the window are ignored
// and read as zero.
//
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   MemRead    : CPU load strobe
//   MemWrite   : CPU store strobe
//   Address    : byte address; [31:4] selects the window, [3:2] the register
//   Write_data : store data
//   Read_data  : load data (zero unless Hit & MemRead)
//   Hit        : address falls inside the 16-byte register window
//   irq        : level interrupt, EXP & IE
module mmio_timer_responder
  import mmio_timer_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
  parameter int          PRESC_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        Hit,
  output logic        irq
);

  // Register state
  logic               en;
  logic               auto_mode;
  logic               ie;
  logic [PRESC_W-1:0] presc;
  logic [31:0]        load_q;
  logic [31:0]        count_q;
  logic               exp_q;

  // Decode
  tmr_reg_e sel;
  logic     wr_ctrl, wr_load, wr_count, wr_status;
  logic     tick, expire;

  // Byte-lane bits are ignored; only full-word accesses exist.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Address[1:0];

  assign Hit = (Address[31:4] == BASE_ADDR[31:4]);
  assign sel = tmr_reg_e'(Address[3:2]);

  assign wr_ctrl   = Hit && MemWrite && (sel == TMR_CTRL);
  assign wr_load   = Hit && MemWrite && (sel == TMR_LOAD);
  assign wr_count  = Hit && MemWrite && (sel == TMR_COUNT);
  assign wr_status = Hit && MemWrite && (sel == TMR_STATUS);

  timer_prescaler #(
    .W (PRESC_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (reset),
    .en    (en),
    .presc (presc),
    .clear (wr_ctrl),
    .tick  (tick)
  );

  // Expiry replaces the decrement when the count is already zero, so the
  // counter can never wrap.
  assign expire = tick && (count_q == 32'd0);

  // CTRL: a software write always wins over the one-shot auto-disable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en        <= 1'b0;
      auto_mode <= 1'b0;
      ie        <= 1'b0;
      presc     <= '0;
    end else if (wr_ctrl) begin
      en        <= Write_data[CTRL_EN];
      auto_mode <= Write_data[CTRL_AUTO];
      ie        <= Write_data[CTRL_IE];
      presc     <= Write_data[CTRL_PRESC_LSB +: PRESC_W];
    end else if (expire && !auto_mode) begin
      en        <= 1'b0;
    end
  end

  // LOAD: a reload on the same edge as a LOAD write samples the old value,
  // which falls out naturally from the registered load_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q <= 32'd0;
    end else if (wr_load) begin
      load_q <= Write_data;
    end
  end

  // COUNT: a software write takes priority over any tick activity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 32'd0;
    end else if (wr_count) begin
      count_q <= Write_data;
    end else if (tick) begin
      if (count_q != 32'd0) begin
        count_q <= count_q - 32'd1;
      end else if (auto_mode) begin
        count_q <= load_q;
      end
    end
  end

  // EXP: sticky, write-1-to-clear; a simultaneous expiry wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q <= 1'b0;
    end else if (expire) begin
      exp_q <= 1'b1;
    end else if (wr_status && Write_data[STATUS_EXP]) begin
      exp_q <= 1'b0;
    end
  end

  assign irq = exp_q && ie;

  // Read mux
  always_comb begin
    Read_data = 32'd0;
    if (Hit && MemRead) begin
      case (sel)
        TMR_CTRL: begin
          Read_data[CTRL_EN]                      = en;
          Read_data[CTRL_AUTO]                    = auto_mode;
          Read_data[CTRL_IE]                      = ie;
          Read_data[CTRL_PRESC_LSB +: PRESC_W]    = presc;
        end
        TMR_LOAD:   Read_data = load_q;
        TMR_COUNT:  Read_data = count_q;
        TMR_STATUS: Read_data[STATUS_EXP] = exp_q;
        default:    Read_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed bench for mmio_timer_responder.
module tb_mmio_timer_responder;

  localparam logic [31:0] A_CTRL   = 32'h0000_FF00;
  localparam logic [31:0] A_LOAD   = 32'h0000_FF04;
  localparam logic [31:0] A_COUNT  = 32'h0000_FF08;
  localparam logic [31:0] A_STATUS = 32'h0000_FF0C;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        Hit;
  logic        irq;

  int vectors;
  int miscompares;

  mmio_timer_responder dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .Hit        (Hit),
    .irq        (irq)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Store: held for one cycle, committed at the next rising edge; returns 1ns after it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    @(posedge clk);
    #1;
    MemWrite   = 1'b0;
    Write_data = 32'd0;
  endtask

  // Load: combinational, no clock edge consumed.
  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    Address = a;
    MemRead = 1'b1;
    #1;
    d = Read_data;
    MemRead = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Address     = 32'd0;
    Write_data  = 32'd0;

    // Reset state
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd_check("rst_ctrl", A_CTRL, 32'd0);
    rd_check("rst_count", A_COUNT, 32'd0);
    reset = 1'b1;
    step(1);

    // Reset asserted mid-count clears immediately
    bus_write(A_COUNT, 32'd5);
    bus_write(A_CTRL, 32'h0000_0001);
    step(1);
    rd_check("midrst_pre_count", A_COUNT, 32'd4);
    reset = 1'b0;
    #1;
    check("midrst_irq", {31'd0, irq}, 32'd0);
    rd_check("midrst_ctrl", A_CTRL, 32'd0);
    rd_check("midrst_count", A_COUNT, 32'd0);
    reset = 1'b1;
    step(2);
    rd_check("postrst_count", A_COUNT, 32'd0);

    // One-shot, PRESC=0
    bus_write(A_LOAD, 32'd0);
    bus_write(A_COUNT, 32'd3);
    bus_write(A_CTRL, 32'h0000_0005);
    rd_check("os_count3", A_COUNT, 32'd3);
    step(1);
    rd_check("os_count2", A_COUNT, 32'd2);
    step(1);
    rd_check("os_count1", A_COUNT, 32'd1);
    step(1);
    rd_check("os_count0", A_COUNT, 32'd0);
    rd_check("os_noexp", A_STATUS, 32'd0);
    step(1);
    rd_check("os_exp", A_STATUS, 32'd1);
    check("os_irq", {31'd0, irq}, 32'd1);
    rd_check("os_en_off", A_CTRL, 32'h0000_0004);
    rd_check("os_count_hold", A_COUNT, 32'd0);
    step(1);
    rd_check("os_count_hold2", A_COUNT, 32'd0);
    check("os_irq_hold", {31'd0, irq}, 32'd1);
    bus_write(A_STATUS, 32'd1);
    check("os_irq_clr", {31'd0, irq}, 32'd0);
    rd_check("os_exp_clr", A_STATUS, 32'd0);

    // Auto-reload, LOAD=2, PRESC=3: tick every 4, expiry every 12
    bus_write(A_LOAD, 32'd2);
    bus_write(A_COUNT, 32'd2);
    bus_write(A_CTRL, 32'h0000_0307);
    step(3);
    rd_check("ar_w3", A_COUNT, 32'd2);
    step(1);
    rd_check("ar_w4", A_COUNT, 32'd1);
    step(4);
    rd_check("ar_w8", A_COUNT, 32'd0);
    rd_check("ar_w8_noexp", A_STATUS, 32'd0);
    step(3);
    rd_check("ar_w11", A_COUNT, 32'd0);
    check("ar_w11_irq", {31'd0, irq}, 32'd0);
    step(1);
    rd_check("ar_w12_reload", A_COUNT, 32'd2);
    rd_check("ar_w12_exp", A_STATUS, 32'd1);
    check("ar_w12_irq", {31'd0, irq}, 32'd1);
    rd_check("ar_w12_ctrl", A_CTRL, 32'h0000_0307);
    step(11);
    rd_check("ar_w23", A_COUNT, 32'd0);
    rd_check("ar_w23_sticky", A_STATUS, 32'd1);
    step(1);
    rd_check("ar_w24_reload", A_COUNT, 32'd2);

    // W1C racing an expiry
    bus_write(A_STATUS, 32'd1);
    rd_check("w1c_clear", A_STATUS, 32'd0);
    check("w1c_irq_low", {31'd0, irq}, 32'd0);
    step(10);
    rd_check("w1c_w35_count", A_COUNT, 32'd0);
    bus_write(A_STATUS, 32'd1);
    rd_check("w1c_race_exp", A_STATUS, 32'd1);
    check("w1c_race_irq", {31'd0, irq}, 32'd1);
    rd_check("w1c_race_reload", A_COUNT, 32'd2);
    bus_write(A_STATUS, 32'd1);
    rd_check("w1c_after", A_STATUS, 32'd0);
    check("w1c_irq_drop", {31'd0, irq}, 32'd0);

    // LOAD write on the reload edge: reload uses the old LOAD
    step(10);
    rd_check("ld_w47_count", A_COUNT, 32'd0);
    bus_write(A_LOAD, 32'd5);
    rd_check("ld_race_count", A_COUNT, 32'd2);
    rd_check("ld_race_load", A_LOAD, 32'd5);
    bus_write(A_CTRL, 32'd0);
    bus_write(A_STATUS, 32'd1);

    // Address decode
    Address = 32'h0000_FE08;
    MemRead = 1'b1;
    #1;
    check("dec_miss_hit", {31'd0, Hit}, 32'd0);
    check("dec_miss_data", Read_data, 32'd0);
    MemRead = 1'b0;
    bus_write(32'h0000_FE04, 32'hDEAD_BEEF);
    Address = 32'h0000_FF07;
    #1;
    check("dec_hit", {31'd0, Hit}, 32'd1);
    rd_check("dec_ff07_load", 32'h0000_FF07, 32'd5);

    // Unimplemented CTRL bits read zero
    bus_write(A_CTRL, 32'hFFFF_FFFE);
    rd_check("ctrl_mask", A_CTRL, 32'h0000_FF06);
    bus_write(A_CTRL, 32'd0);

    // COUNT write on a tick edge wins over the decrement
    bus_write(A_COUNT, 32'd10);
    bus_write(A_CTRL, 32'h0000_0001);
    rd_check("cw_count10", A_COUNT, 32'd10);
    step(1);
    rd_check("cw_count9", A_COUNT, 32'd9);
    bus_write(A_COUNT, 32'd100);
    rd_check("cw_count100", A_COUNT, 32'd100);
    step(1);
    rd_check("cw_count99", A_COUNT, 32'd99);

    // CTRL write on a one-shot expiry edge: written EN wins
    bus_write(A_COUNT, 32'd0);
    bus_write(A_CTRL, 32'h0000_0001);
    rd_check("ce_ctrl_en", A_CTRL, 32'h0000_0001);
    rd_check("ce_exp", A_STATUS, 32'd1);
    step(1);
    rd_check("ce_oneshot_off", A_CTRL, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
